rule_scan_engine: RTL and testbench
===================================

// Module: rule_scan_engine
// PURPOSE
// Linear first-match packet classifier. Accepts one packet_s header, streams rule_s entries
// from an external rule table (1-cycle read latency), and evaluates each entry against the
// latched packet with a rule_match instance. Returns hit/miss and the index of the
// lowest-numbered matching rule. Sits between the header parser (upstream) and the action
// lookup (downstream), and owns the rule_match stage.
// PARAMETERS
// NUM_RULES   64                    rule table depth; >=1
// IDX_W       $clog2(NUM_RULES)     localparam; rule index width (1 if NUM_RULES==1)
// PORTS
// clk               in   1                 clock; all logic on posedge
// rst               in   1                 synchronous, active-high reset
// pkt_valid         in   1                 upstream header valid
// pkt_ready         out  1                 engine can accept a header
// pkt               in   $bits(packet_s)   header: protocol, src/dst ip+port
// num_rules_active  in   IDX_W+1           loaded rule count; sampled on pkt accept
// rule_rd_en        out  1                 rule table read strobe
// rule_rd_addr      out  IDX_W             rule table read address
// rule_rd_data      in   $bits(rule_s)     entry for the address strobed in the previous cycle
// res_valid         out  1                 result valid
// res_ready         in   1                 downstream accepts result
// res_hit           out  1                 1 = some rule matched
// res_idx           out  IDX_W             lowest matching rule index; 0 on miss
// BEHAVIOUR
// - Reset: state IDLE; res_valid=0, res_hit=0, res_idx=0, rule_rd_en=0, rule_rd_addr=0.
//   pkt_ready=(state==IDLE)&&!rst. rst mid-scan or mid-result aborts; no result is emitted.
// - FSM states IDLE, SCAN, DONE. Accept = pkt_valid&&pkt_ready, at clock edge E0 (IDLE only).
// - On accept: latch pkt; latch n=min(num_rules_active,NUM_RULES).
//   n==0 -> DONE with hit=0, idx=0; res_valid is high in the cycle after E0.
//   n>0  -> SCAN.
// - SCAN issue side: rule_rd_en=1 and rule_rd_addr=0 in the first SCAN cycle, incrementing by
//   1 per cycle. No read is issued for an address >= n, and none is issued after a match is seen.
// - SCAN compare side: a data-valid flag delayed one cycle from rule_rd_en qualifies
//   rule_rd_data. The entry is checked by rule_match against the latched pkt: all fields are
//   inclusive ranges, start<=field<=last.
// - First qualified match at index k: res_hit=1, res_idx=k, go to DONE. res_valid is high
//   k+3 cycles after E0. Any read already in flight is discarded.
// - No match through index n-1: res_hit=0, res_idx=0, go to DONE. res_valid is high
//   n+2 cycles after E0.
// - DONE: res_valid=1. res_hit and res_idx are held stable until res_valid&&res_ready.
//   On that handshake go to IDLE; pkt_ready rises the next cycle. Packets never overlap.
// - Overlapping rules: the lowest index always wins. A changed num_rules_active mid-scan is ignored.
// - Throughput: one rule per cycle; per-packet occupancy is k+4 or n+3 cycles, plus result stall.
// TESTING
// 1 n=4, only rule 2 matches (proto 6, dst port 80) -> res_hit=1, res_idx=2, res_valid 5 cycles after E0.
// 2 n=4, no rule matches -> res_hit=0, res_idx=0, res_valid 6 cycles after E0; reads only to addrs 0..3.
// 3 rules 1 and 3 both match -> res_idx=1; no rule_rd_en for addr 3 after the match.
// 4 num_rules_active=0 -> miss 1 cycle after E0, no rule_rd_en; num_rules_active=NUM_RULES+5
//   -> reads clamp at NUM_RULES-1.
// 5 res_ready held low 10 cycles in DONE -> res_hit/res_idx stable, pkt_ready=0 throughout.
// 6 rst asserted in the 2nd SCAN cycle -> res_valid never rises, rule_rd_en=0 next cycle,
//   pkt_ready=1 after rst drops; the next packet classifies correctly.

Source files
------------

// File: rtl/rule_scan_engine.sv
// Linear first-match packet classifier: latches one header, streams rule entries from an
// external 1-cycle-latency table and reports the lowest-numbered matching rule.
package rule_scan_pkg;
  typedef struct packed {
    logic [7:0]  proto;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
  } packet_s;

  typedef struct packed {
    logic [7:0]  proto_start;
    logic [7:0]  proto_last;
    logic [31:0] src_ip_start;
    logic [31:0] src_ip_last;
    logic [31:0] dst_ip_start;
    logic [31:0] dst_ip_last;
    logic [15:0] src_port_start;
    logic [15:0] src_port_last;
    logic [15:0] dst_port_start;
    logic [15:0] dst_port_last;
  } rule_s;
endpackage

module rule_match
  import rule_scan_pkg::*;
(
  input  packet_s pkt,
  input  rule_s   rule,
  output logic    match
);
  // Every field is an inclusive range; an entry with start > last can never match.
  assign match = (pkt.proto    >= rule.proto_start)    && (pkt.proto    <= rule.proto_last)    &&
                 (pkt.src_ip   >= rule.src_ip_start)   && (pkt.src_ip   <= rule.src_ip_last)   &&
                 (pkt.dst_ip   >= rule.dst_ip_start)   && (pkt.dst_ip   <= rule.dst_ip_last)   &&
                 (pkt.src_port >= rule.src_port_start) && (pkt.src_port <= rule.src_port_last) &&
                 (pkt.dst_port >= rule.dst_port_start) && (pkt.dst_port <= rule.dst_port_last);
endmodule

// Handshakes: a transfer happens on a rising edge where valid && ready; valid is never
// withdrawn and its payload never changes until that transfer.
module rule_scan_engine
  import rule_scan_pkg::*;
#(
  parameter  int NUM_RULES = 64,
  localparam int IDX_W     = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pkt_valid,
  output logic             pkt_ready,
  input  packet_s          pkt,
  input  logic [IDX_W:0]   num_rules_active,
  output logic             rule_rd_en,
  output logic [IDX_W-1:0] rule_rd_addr,
  input  rule_s            rule_rd_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_hit,
  output logic [IDX_W-1:0] res_idx
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  localparam logic [IDX_W:0] MAX_N = (IDX_W+1)'(NUM_RULES);

  state_e           state_q, state_d;
  packet_s          pkt_q;
  logic [IDX_W:0]   n_q, n_in;
  logic [IDX_W:0]   addr_q;     // next address to issue
  logic [IDX_W:0]   cmp_idx_q;  // index of the entry on rule_rd_data
  logic             dv_q;       // rule_rd_data is a response to last cycle's read
  logic             res_hit_q;
  logic [IDX_W-1:0] res_idx_q;
  logic             entry_match, hit_now, last_cmp, accept;

  rule_match u_match (
    .pkt   (pkt_q),
    .rule  (rule_rd_data),
    .match (entry_match)
  );

  assign n_in     = (num_rules_active > MAX_N) ? MAX_N : num_rules_active;
  assign hit_now  = dv_q && entry_match;
  assign last_cmp = dv_q && (cmp_idx_q == n_q - 1'b1);
  assign accept   = pkt_valid && pkt_ready;

  assign rule_rd_addr = addr_q[IDX_W-1:0];
  assign res_hit      = res_hit_q;
  assign res_idx      = res_idx_q;

  always_comb begin
    state_d    = state_q;
    pkt_ready  = (state_q == IDLE) && !rst;
    rule_rd_en = 1'b0;
    res_valid  = (state_q == DONE) && !rst;
    case (state_q)
      IDLE: if (accept) state_d = (n_in == '0) ? DONE : SCAN;
      SCAN: begin
        // Stop issuing the moment a match is visible so no further entries are fetched.
        rule_rd_en = (addr_q < n_q) && !hit_now && !rst;
        if (hit_now || last_cmp) state_d = DONE;
      end
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pkt_q     <= '0;
      n_q       <= '0;
      addr_q    <= '0;
      cmp_idx_q <= '0;
      dv_q      <= 1'b0;
      res_hit_q <= 1'b0;
      res_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      dv_q      <= rule_rd_en;
      cmp_idx_q <= addr_q;
      if (rule_rd_en) addr_q <= addr_q + 1'b1;
      if (accept) begin
        pkt_q     <= pkt;
        n_q       <= n_in;
        addr_q    <= '0;
        res_hit_q <= 1'b0;
        res_idx_q <= '0;
      end
      if (state_q == SCAN && hit_now) begin
        res_hit_q <= 1'b1;
        res_idx_q <= cmp_idx_q[IDX_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_rule_scan_engine.sv
// Bench for rule_scan_engine: table of packets against a fixed rule table, latency and
// read-pattern checks, plus result-stall and mid-scan reset sequences.
module tb_rule_scan_engine;
  import rule_scan_pkg::*;

  localparam int NUM_RULES = 8;
  localparam int IDX_W     = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pkt_valid = 1'b0;
  logic             pkt_ready;
  packet_s          pkt = '0;
  logic [IDX_W:0]   num_rules_active = '0;
  logic             rule_rd_en;
  logic [IDX_W-1:0] rule_rd_addr;
  rule_s            rule_rd_data = '0;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic             res_hit;
  logic [IDX_W-1:0] res_idx;

  rule_scan_engine #(.NUM_RULES(NUM_RULES)) dut (
    .clk              (clk),
    .rst              (rst),
    .pkt_valid        (pkt_valid),
    .pkt_ready        (pkt_ready),
    .pkt              (pkt),
    .num_rules_active (num_rules_active),
    .rule_rd_en       (rule_rd_en),
    .rule_rd_addr     (rule_rd_addr),
    .rule_rd_data     (rule_rd_data),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_hit          (res_hit),
    .res_idx          (res_idx)
  );

  // clock / reset
  always #5 clk = ~clk;

  // rule table with one-cycle read latency
  rule_s rtable [NUM_RULES];
  always @(posedge clk) if (rule_rd_en) rule_rd_data <= rtable[rule_rd_addr];

  // read monitor: addresses must run 0,1,2,... within one packet
  int rd_count = 0;
  bit seq_err  = 0;
  always @(negedge clk) begin
    if (!rst && rule_rd_en) begin
      if (int'(rule_rd_addr) != rd_count) seq_err = 1;
      rd_count++;
    end
  end

  int total = 0;
  int bad   = 0;
  logic [IDX_W:0] exp_q [$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic rule_s make_rule(input logic [7:0] p_lo, input logic [7:0] p_hi,
                                      input logic [31:0] d_lo, input logic [31:0] d_hi,
                                      input logic [15:0] dp_lo, input logic [15:0] dp_hi);
    rule_s r;
    r.proto_start    = p_lo;   r.proto_last    = p_hi;
    r.src_ip_start   = '0;     r.src_ip_last   = '1;
    r.dst_ip_start   = d_lo;   r.dst_ip_last   = d_hi;
    r.src_port_start = '0;     r.src_port_last = '1;
    r.dst_port_start = dp_lo;  r.dst_port_last = dp_hi;
    return r;
  endfunction

  typedef struct {
    string       name;
    logic [7:0]  proto;
    logic [31:0] dst_ip;
    logic [15:0] dst_port;
    int          n_act;
    logic        exp_hit;
    int          exp_idx;
    int          exp_lat;
    int          exp_reads;
  } vec_t;

  vec_t vecs [13];

  // driver: one packet, result compared through the expected queue
  task automatic run_vec(input vec_t v, input int stall);
    packet_s p;
    logic [IDX_W:0] e;
    int cyc = 0;
    bit got = 0;
    p.proto    = v.proto;
    p.src_ip   = $urandom;
    p.dst_ip   = v.dst_ip;
    p.src_port = 16'($urandom_range(0, 65535));
    p.dst_port = v.dst_port;
    @(negedge clk);
    check({v.name, ".pkt_ready_idle"}, pkt_ready, 1);
    pkt = p;
    pkt_valid = 1'b1;
    num_rules_active = (IDX_W+1)'(v.n_act);
    rd_count = 0;
    seq_err = 0;
    exp_q.push_back({v.exp_hit, IDX_W'(v.exp_idx)});
    @(posedge clk);
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      pkt_valid = 1'b0;
      num_rules_active = (IDX_W+1)'($urandom_range(0, 15));
      if (res_valid) got = 1;
    end
    check({v.name, ".latency"}, got ? cyc : -1, v.exp_lat);
    e = exp_q.pop_front();
    if (got) begin
      check({v.name, ".hit"}, res_hit, e[IDX_W]);
      check({v.name, ".idx"}, res_idx, e[IDX_W-1:0]);
      if (stall > 0) begin
        res_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
          @(negedge clk);
          check({v.name, ".stall_valid"}, res_valid, 1);
          check({v.name, ".stall_hit"}, res_hit, e[IDX_W]);
          check({v.name, ".stall_idx"}, res_idx, e[IDX_W-1:0]);
          check({v.name, ".stall_pkt_ready"}, pkt_ready, 0);
        end
        res_ready = 1'b1;
      end
      @(negedge clk);
      check({v.name, ".valid_drop"}, res_valid, 0);
      check({v.name, ".pkt_ready_back"}, pkt_ready, 1);
    end
    check({v.name, ".reads"}, rd_count, v.exp_reads);
    check({v.name, ".read_order"}, seq_err, 0);
  endtask

  initial begin
    for (int i = 0; i < NUM_RULES; i++) rtable[i] = make_rule(8'd1, 8'd0, '0, '1, '0, '1);
    rtable[0] = make_rule(8'd17, 8'd17, '0, '1, '0, '1);
    rtable[1] = make_rule(8'd6, 8'd6, '0, '1, 16'd443, 16'd443);
    rtable[2] = make_rule(8'd6, 8'd6, '0, '1, 16'd80, 16'd80);
    rtable[3] = make_rule(8'd6, 8'd6, '0, '1, 16'd443, 16'd8080);
    rtable[4] = make_rule(8'd1, 8'd1, '0, '1, '0, '1);
    rtable[5] = make_rule(8'd6, 8'd6, 32'h0A00_0000, 32'h0A00_00FF, '0, '1);
    rtable[7] = make_rule(8'd47, 8'd47, '0, '1, '0, '1);

    //          name            proto  dst_ip        dport    n  hit idx lat reads
    vecs[0]  = '{"r2_dport80",   8'd6,  32'hC0A80001, 16'd80,  4, 1, 2, 5,  3};
    vecs[1]  = '{"miss_n4",      8'd6,  32'hC0A80001, 16'd22,  4, 0, 0, 6,  4};
    vecs[2]  = '{"overlap_1_3",  8'd6,  32'hC0A80001, 16'd443, 4, 1, 1, 4,  2};
    vecs[3]  = '{"n_zero",       8'd6,  32'hC0A80001, 16'd80,  0, 0, 0, 1,  0};
    vecs[4]  = '{"clamp_hit7",   8'd47, 32'hC0A80001, 16'd22, 13, 1, 7, 10, 8};
    vecs[5]  = '{"clamp_miss",   8'd99, 32'hC0A80001, 16'd22, 13, 0, 0, 10, 8};
    vecs[6]  = '{"r0_n1",        8'd17, 32'hC0A80001, 16'd53,  1, 1, 0, 3,  1};
    vecs[7]  = '{"ip_hi_edge",   8'd6,  32'h0A0000FF, 16'd22,  8, 1, 5, 8,  6};
    vecs[8]  = '{"ip_lo_edge",   8'd6,  32'h0A000000, 16'd22,  8, 1, 5, 8,  6};
    vecs[9]  = '{"ip_past",      8'd6,  32'h0A000100, 16'd22,  8, 0, 0, 10, 8};
    vecs[10] = '{"icmp_n5",      8'd1,  32'hC0A80001, 16'd22,  5, 1, 4, 7,  5};
    vecs[11] = '{"icmp_n4",      8'd1,  32'hC0A80001, 16'd22,  4, 0, 0, 6,  4};
    vecs[12] = '{"last_idx_n3",  8'd6,  32'hC0A80001, 16'd80,  3, 1, 2, 5,  3};

    // reset state
    repeat (3) @(negedge clk);
    check("rst.pkt_ready", pkt_ready, 0);
    check("rst.res_valid", res_valid, 0);
    check("rst.rd_en", rule_rd_en, 0);
    rst = 1'b0;
    #1;
    check("rst.pkt_ready_after", pkt_ready, 1);
    check("rst.res_hit", res_hit, 0);
    check("rst.res_idx", res_idx, 0);
    check("rst.rd_addr", rule_rd_addr, 0);

    foreach (vecs[i]) run_vec(vecs[i], 0);

    // result held under downstream backpressure
    run_vec(vecs[0], 10);

    // reset in the second scan cycle aborts the packet
    begin
      int rises = 0;
      @(negedge clk);
      pkt = '{proto: 8'd6, src_ip: 32'h1, dst_ip: 32'hC0A80001, src_port: 16'd1, dst_port: 16'd22};
      pkt_valid = 1'b1;
      num_rules_active = 4'd4;
      @(posedge clk);
      @(negedge clk);
      pkt_valid = 1'b0;
      check("abort.first_scan_rd_en", rule_rd_en, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort.rd_en_off", rule_rd_en, 0);
      check("abort.valid_off", res_valid, 0);
      rst = 1'b0;
      #1;
      check("abort.pkt_ready", pkt_ready, 1);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (res_valid) rises++;
      end
      check("abort.no_result", rises, 0);
      run_vec(vecs[2], 0);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
